// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the writeback path: operand, physical register
// and the queued result entry.
package wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int CORE_WIDTH = 2;
  localparam int CORE_SIZE  = 64;
  localparam int PREG_W     = $clog2(CORE_SIZE);

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t dst;
    xlen_t opd;
  } wb_ent_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-FU result queue; full/empty come from registered pointers only.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    flush,
  input  logic    push,
  input  wb_ent_t din,
  input  logic    pop,
  output wb_ent_t head,
  output logic    empty,
  output logic    full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp;
  logic [AW:0] rp;
  wb_ent_t     mem [DEPTH];

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_FU result queues drained round-robin onto WIDTH
// register-file lanes. Define WB_BYPASS_EN for empty-queue bypass.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int WIDTH  = CORE_WIDTH,
  parameter int DEPTH  = 2,
  parameter int SIZE   = CORE_SIZE
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_valid,
  output logic [NUM_FU-1:0]       fu_ready,
  input  preg_t [NUM_FU-1:0]      fu_dst,
  input  xlen_t [NUM_FU-1:0]      fu_opd,
  output logic [WIDTH-1:0]        wb_valid,
  output preg_t [WIDTH-1:0]       wb_dst,
  output xlen_t [WIDTH-1:0]       wb_opd
);

  localparam int PW = $clog2(NUM_FU > 1 ? NUM_FU : 2);
  localparam int CW = $clog2(WIDTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_arbiter: DEPTH must be a power of 2 >= 2");
  end
  if ($clog2(SIZE) != PREG_W) begin : g_bad_size
    $error("wb_arbiter: SIZE does not match preg_t");
  end

  logic [NUM_FU-1:0] empty, full, ok, byp;
  logic [NUM_FU-1:0] push, pop, cand_v, grant;
  wb_ent_t           head [NUM_FU];
  wb_ent_t           cand [NUM_FU];

  logic [PW-1:0]     rr_ptr, rr_nxt;
  logic [WIDTH-1:0]  lane_v;
  wb_ent_t           lane [WIDTH];

  assign fu_ready = ~full;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    // zero-dst results complete the handshake but never enter a queue
    assign ok[i] = fu_valid[i] & fu_ready[i] & ~flush &
                   (fu_dst[i] != '0);
`ifdef WB_BYPASS_EN
    assign byp[i] = ok[i] & empty[i];
`else
    assign byp[i] = 1'b0;
`endif
    assign cand_v[i] = (~empty[i] & ~flush) | byp[i];
    assign cand[i]   = empty[i] ? wb_ent_t'({fu_dst[i], fu_opd[i]})
                                : head[i];
    assign push[i]   = ok[i] & ~(byp[i] & grant[i]);
    assign pop[i]    = grant[i] & ~empty[i];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push[i]),
      .din     (wb_ent_t'({fu_dst[i], fu_opd[i]})),
      .pop     (pop[i]),
      .head    (head[i]),
      .empty   (empty[i]),
      .full    (full[i])
    );
  end

  always_comb begin
    logic [PW:0]   s;
    logic [PW:0]   n;
    logic [PW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          hit;
    s      = '0;
    n      = '0;
    idx    = '0;
    cnt    = '0;
    hit    = 1'b0;
    grant  = '0;
    lane_v = '0;
    rr_nxt = rr_ptr;
    for (int w = 0; w < WIDTH; w++) lane[w] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      s = {1'b0, rr_ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(NUM_FU)) s = s - (PW+1)'(NUM_FU);
      idx = s[PW-1:0];
      // a head colliding with an earlier grant's dst waits in place
      hit = 1'b0;
      for (int w = 0; w < WIDTH; w++) begin
        if (lane_v[w] && lane[w].dst == cand[idx].dst) hit = 1'b1;
      end
      if (cand_v[idx] && !hit && cnt < CW'(WIDTH)) begin
        for (int w = 0; w < WIDTH; w++) begin
          if (cnt == CW'(w)) begin
            lane_v[w] = 1'b1;
            lane[w]   = cand[idx];
          end
        end
        grant[idx] = 1'b1;
        cnt        = cnt + 1'b1;
        n          = s + 1'b1;
        if (n >= (PW+1)'(NUM_FU)) n = '0;
        rr_nxt = n[PW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      wb_valid <= '0;
      wb_dst   <= '0;
      wb_opd   <= '0;
    end else begin
      rr_ptr   <= rr_nxt;
      wb_valid <= lane_v;
      for (int w = 0; w < WIDTH; w++) begin
        wb_dst[w] <= lane[w].dst;
        wb_opd[w] <= lane[w].opd;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter in its default build
// (WB_BYPASS_EN undefined).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic             clock;
  logic             reset_n;
  logic             flush;
  logic [3:0]       fu_valid;
  logic [3:0]       fu_ready;
  preg_t [3:0]      fu_dst;
  xlen_t [3:0]      fu_opd;
  logic [1:0]       wb_valid;
  preg_t [1:0]      wb_dst;
  xlen_t [1:0]      wb_opd;

  int nvec = 0;
  int nbad = 0;

  int        writes;
  int        doubles;
  logic [7:0] q2 [$];
  logic [1:0] orv;
  logic       hs2;

  wb_arbiter #(
    .NUM_FU (4),
    .WIDTH  (2),
    .DEPTH  (2),
    .SIZE   (64)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_ready (fu_ready),
    .fu_dst   (fu_dst),
    .fu_opd   (fu_opd),
    .wb_valid (wb_valid),
    .wb_dst   (wb_dst),
    .wb_opd   (wb_opd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    fu_valid = '0;
    fu_dst   = '0;
    fu_opd   = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic grab();
    for (int w = 0; w < 2; w++) begin
      if (wb_valid[w]) begin
        writes++;
        if (wb_opd[w][7:4] == 4'h2) q2.push_back(wb_opd[w][7:0]);
      end
    end
    if (&wb_valid) doubles++;
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    clr();
    #2;
    chk("rst_valid", wb_valid, 0);
    chk("rst_dst", wb_dst, 0);
    chk("rst_opd", wb_opd, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", fu_ready, 4'hf);

    // single result, 2-edge latency
    fu_valid[1] = 1'b1;
    fu_dst[1]   = 6'd5;
    fu_opd[1]   = 32'hDEAD;
    tick();
    clr();
    chk("single_n", wb_valid, 0);
    tick();
    chk("single_v", wb_valid, 2'b01);
    chk("single_dst", wb_dst[0], 5);
    chk("single_opd", wb_opd[0], 32'hDEAD);
    chk("single_l1d", wb_dst[1], 0);
    chk("single_l1o", wb_opd[1], 0);
    tick();
    chk("single_off", wb_valid, 0);

    // four FUs at once from rr_ptr = 0
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      fu_valid[i] = 1'b1;
      fu_dst[i]   = preg_t'(i + 1);
      fu_opd[i]   = 32'h100 + i;
    end
    tick();
    clr();
    tick();
    chk("rr_a_v", wb_valid, 2'b11);
    chk("rr_a_d0", wb_dst[0], 1);
    chk("rr_a_d1", wb_dst[1], 2);
    tick();
    chk("rr_b_v", wb_valid, 2'b11);
    chk("rr_b_d0", wb_dst[0], 3);
    chk("rr_b_d1", wb_dst[1], 4);
    chk("rr_b_o1", wb_opd[1], 32'h103);
    fu_valid  = 4'b1001;
    fu_dst[0] = 6'd8;
    fu_dst[3] = 6'd9;
    tick();
    clr();
    tick();
    chk("rr_end_d0", wb_dst[0], 8);
    chk("rr_end_d1", wb_dst[1], 9);

    // same dst from two FUs never shares a cycle
    fu_valid  = 4'b0011;
    fu_dst[0] = 6'd7;
    fu_dst[1] = 6'd7;
    fu_opd[0] = 32'h11;
    fu_opd[1] = 32'h22;
    tick();
    clr();
    tick();
    chk("waw_1_v", wb_valid, 2'b01);
    chk("waw_1_o", wb_opd[0], 32'h11);
    tick();
    chk("waw_2_v", wb_valid, 2'b01);
    chk("waw_2_o", wb_opd[0], 32'h22);
    tick();
    chk("waw_off", wb_valid, 0);

    // backpressure on FU2 via dst collisions
    do_reset();
    tick();
    writes  = 0;
    doubles = 0;
    q2.delete();
    fu_valid  = 4'b0111;
    fu_dst[0] = 6'd12;
    fu_dst[1] = 6'd12;
    fu_dst[2] = 6'd12;
    fu_opd[0] = 32'h0A;
    fu_opd[1] = 32'h0B;
    fu_opd[2] = 32'h20;
    for (int c = 1; c <= 5; c++) begin
      hs2 = fu_ready[2];
      tick();
      grab();
      if (hs2) fu_opd[2] = fu_opd[2] + 1;
      if (c == 2) begin
        chk("bp_rdy2", fu_ready, 4'b1001);
        chk("bp_o2", wb_opd[0], 32'h0A);
      end
      if (c == 3) begin
        chk("bp_rdy3", fu_ready, 4'b1010);
        chk("bp_o3", wb_opd[0], 32'h0B);
      end
      if (c == 4) begin
        chk("bp_rdy4", fu_ready, 4'b1100);
        chk("bp_o4", wb_opd[0], 32'h20);
        fu_valid = 4'b0100;
      end
    end
    chk("bp_last_opd", fu_opd[2], 32'h23);
    clr();
    for (int c = 0; c < 15; c++) begin
      tick();
      grab();
    end
    chk("bp_writes", writes, 9);
    chk("bp_doubles", doubles, 0);
    chk("bp_q2_n", q2.size(), 3);
    if (q2.size() == 3) begin
      chk("bp_q2_0", q2[0], 8'h20);
      chk("bp_q2_1", q2[1], 8'h21);
      chk("bp_q2_2", q2[2], 8'h22);
    end
    chk("bp_ready", fu_ready, 4'hf);

    // zero dst accepted and dropped
    fu_valid[3] = 1'b1;
    fu_dst[3]   = 6'd0;
    fu_opd[3]   = 32'hFFFF;
    chk("z_ready", fu_ready[3], 1'b1);
    tick();
    clr();
    orv = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      orv = orv | wb_valid;
    end
    chk("z_never", orv, 0);
    chk("z_ready2", fu_ready, 4'hf);

    // reset mid-flight
    fu_valid  = 4'b1011;
    fu_dst[0] = 6'd20;
    fu_dst[1] = 6'd21;
    fu_dst[3] = 6'd22;
    fu_opd[0] = 32'hA0;
    fu_opd[1] = 32'hA1;
    fu_opd[3] = 32'hA3;
    tick();
    clr();
    tick();
    chk("mr_pre_v", wb_valid, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("mr_v", wb_valid, 0);
    chk("mr_d", wb_dst, 0);
    chk("mr_o", wb_opd, 0);
    #1;
    reset_n = 1'b1;
    orv = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      orv = orv | wb_valid;
    end
    chk("mr_after", orv, 0);
    chk("mr_ready", fu_ready, 4'hf);

    // flush mid-flight, with a blocked offer in the flush cycle
    fu_valid  = 4'b1011;
    fu_dst[0] = 6'd23;
    fu_dst[1] = 6'd24;
    fu_dst[3] = 6'd25;
    tick();
    clr();
    tick();
    chk("fl_pre_v", wb_valid, 2'b11);
    flush       = 1'b1;
    fu_valid[2] = 1'b1;
    fu_dst[2]   = 6'd26;
    tick();
    flush = 1'b0;
    clr();
    chk("fl_v", wb_valid, 0);
    orv = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      orv = orv | wb_valid;
    end
    chk("fl_after", orv, 0);
    chk("fl_ready", fu_ready, 4'hf);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
